// File: rtl/lstm_axi_cmd_sequencer.sv
// Single-outstanding AXI4-Lite master: turns valid/ready commands into AXI4-Lite reads/writes.
// Optional write read-back verification is enabled by defining LSTM_SEQ_READBACK_EN.
module lstm_axi_cmd_sequencer #(
  parameter int unsigned AXI_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_we,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [AXI_WIDTH-1:0]   cmd_wdata,
  output logic                   rsp_valid,
  output logic [AXI_WIDTH-1:0]   rsp_data,
  output logic                   rsp_err,
  output logic [ADDR_WIDTH-1:0]  m_awaddr,
  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [AXI_WIDTH-1:0]   m_wdata,
  output logic [AXI_WIDTH/8-1:0] m_wstrb,
  output logic                   m_wvalid,
  input  logic                   m_wready,
  input  logic [1:0]             m_bresp,
  input  logic                   m_bvalid,
  output logic                   m_bready,
  output logic [ADDR_WIDTH-1:0]  m_araddr,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  input  logic [AXI_WIDTH-1:0]   m_rdata,
  input  logic [1:0]             m_rresp,
  input  logic                   m_rvalid,
  output logic                   m_rready
);

  localparam int unsigned STRB_W = AXI_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_AR,
    RD_R,
`ifdef LSTM_SEQ_READBACK_EN
    VFY_AR,
    VFY_R,
`endif
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  cmd_ready_q, rsp_valid_q, bready_q, rready_q;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [AXI_WIDTH-1:0]  wdata_q, wdata_d, data_q, data_d;
  logic                  err_q, err_d;
  logic                  unused_resp_lsb;

  // Only bit 1 of a response distinguishes OKAY/EXOKAY from SLVERR/DECERR.
  assign unused_resp_lsb = m_bresp[0] ^ m_rresp[0];

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          awaddr_d = cmd_addr;
          araddr_d = cmd_addr;
          wdata_d  = cmd_wdata;
          data_d   = '0;
          err_d    = 1'b0;
          if (cmd_we) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        // AW and W retire independently; leave once neither is pending.
        if (awvalid_q && m_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WR_B;
      end
      WR_B: begin
        if (bready_q && m_bvalid) begin
          err_d = m_bresp[1];
`ifdef LSTM_SEQ_READBACK_EN
          state_d   = VFY_AR;
          arvalid_d = 1'b1;
`else
          state_d   = RESP;
`endif
        end
      end
      RD_AR: begin
        if (arvalid_q && m_arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (rready_q && m_rvalid) begin
          data_d  = m_rdata;
          err_d   = m_rresp[1];
          state_d = RESP;
        end
      end
`ifdef LSTM_SEQ_READBACK_EN
      VFY_AR: begin
        if (arvalid_q && m_arready) begin
          arvalid_d = 1'b0;
          state_d   = VFY_R;
        end
      end
      VFY_R: begin
        // Accumulate the write's bresp with the read-back status and compare.
        if (rready_q && m_rvalid) begin
          data_d  = m_rdata;
          err_d   = err_q | m_rresp[1] | (m_rdata != wdata_q);
          state_d = RESP;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; handshake outputs follow the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RESP);
      bready_q    <= (state_d == WR_B);
`ifdef LSTM_SEQ_READBACK_EN
      rready_q    <= (state_d == RD_R) || (state_d == VFY_R);
`else
      rready_q    <= (state_d == RD_R);
`endif
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign m_awaddr  = awaddr_q;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = {STRB_W{1'b1}};
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign m_araddr  = araddr_q;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;

endmodule

// File: tb/tb_lstm_axi_cmd_sequencer.sv
// Bench for lstm_axi_cmd_sequencer: randomized AXI4-Lite slave plus a memory-level reference model.
module tb_lstm_axi_cmd_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic          clk;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic          m_awvalid, m_awready, m_wvalid, m_wready;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [3:0]    m_wstrb;
  logic [1:0]    m_bresp, m_rresp;
  logic          m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  lstm_axi_cmd_sequencer #(.AXI_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int checks = 0;
  int errors = 0;

  // Slave knobs, set by the stimulus before each command.
  int unsigned ready_pct = 100;
  logic inj_berr = 1'b0, inj_rerr = 1'b0, inj_corrupt = 1'b0;
  logic b_hold = 1'b0, w_delay_mode = 1'b0;

  // Handshake counters maintained by the slave process.
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;

  logic [DW-1:0] slv_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AXI4-Lite slave: decides ready/valid at each falling edge and records the
  // handshakes that the following rising edge will complete.
  initial begin : slave
    logic hs_aw, hs_w, hs_ar, hs_b, hs_r, p_awv, p_wv, p_arv;
    logic have_aw, have_w, have_ar, b_pending;
    logic [AW-1:0] p_awaddr, p_araddr, aw_addr, ar_addr;
    logic [DW-1:0] p_wdata, w_data;
    int w_wait;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = '0;
        {hs_aw, hs_w, hs_ar, hs_b, hs_r, p_awv, p_wv, p_arv} = '0;
        {have_aw, have_w, have_ar, b_pending} = '0;
        p_awaddr = '0; p_araddr = '0; p_wdata = '0; aw_addr = '0; ar_addr = '0; w_data = '0;
        w_wait = 0;
      end else begin
        if (p_awv && !hs_aw) begin
          chk("awvalid_held", m_awvalid, 1);
          chk("awaddr_stable", m_awaddr, p_awaddr);
        end
        if (p_wv && !hs_w) begin
          chk("wvalid_held", m_wvalid, 1);
          chk("wdata_stable", m_wdata, p_wdata);
        end
        if (p_arv && !hs_ar) begin
          chk("arvalid_held", m_arvalid, 1);
          chk("araddr_stable", m_araddr, p_araddr);
        end
        if (hs_b) m_bvalid = 1'b0;
        if (hs_r) m_rvalid = 1'b0;
        if (w_wait > 0) w_wait--;
        if (hs_aw) begin
          have_aw = 1'b1; aw_addr = p_awaddr;
          if (w_delay_mode) w_wait = 5;
        end
        if (hs_w) begin have_w = 1'b1; w_data = p_wdata; end
        if (hs_ar) begin have_ar = 1'b1; ar_addr = p_araddr; end
        if (w_delay_mode && w_wait > 0) begin
          chk("awvalid_dropped_during_w_stall", m_awvalid, 0);
          chk("wvalid_waits_for_wready", m_wvalid, 1);
        end
        if (have_aw && have_w && !b_pending) begin
          slv_mem[aw_addr] = w_data;
          have_aw = 1'b0; have_w = 1'b0; b_pending = 1'b1;
        end
        if (b_pending && !m_bvalid && !b_hold) begin
          m_bvalid = 1'b1; m_bresp = inj_berr ? 2'b10 : 2'b00; b_pending = 1'b0;
        end
        if (have_ar && !m_rvalid) begin
          m_rvalid = 1'b1;
          m_rdata  = inj_corrupt ? '0 : (slv_mem.exists(ar_addr) ? slv_mem[ar_addr] : '0);
          m_rresp  = inj_rerr ? 2'b10 : 2'b00;
          have_ar  = 1'b0;
        end
        m_awready = ($urandom_range(99) < ready_pct);
        m_arready = ($urandom_range(99) < ready_pct);
        m_wready  = w_delay_mode ? (have_aw && w_wait == 0) : ($urandom_range(99) < ready_pct);
        hs_aw = m_awvalid && m_awready;
        hs_w  = m_wvalid && m_wready;
        hs_ar = m_arvalid && m_arready;
        hs_b  = m_bvalid && m_bready;
        hs_r  = m_rvalid && m_rready;
        n_aw += int'(hs_aw); n_w += int'(hs_w); n_ar += int'(hs_ar);
        n_b  += int'(hs_b);  n_r += int'(hs_r);
        p_awv = m_awvalid; p_wv = m_wvalid; p_arv = m_arvalid;
        p_awaddr = m_awaddr; p_araddr = m_araddr; p_wdata = m_wdata;
      end
    end
  end

  // Expected response from the memory-level view of one command.
  task automatic model(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       output logic [DW-1:0] ed, output logic ee);
    logic [DW-1:0] rb;
    if (we) begin
      ref_mem[addr] = wd;
      rb = inj_corrupt ? '0 : wd;
`ifdef LSTM_SEQ_READBACK_EN
      ed = rb;
      ee = inj_berr | inj_rerr | (rb != wd);
`else
      ed = '0;
      ee = inj_berr;
`endif
    end else begin
      rb = ref_mem.exists(addr) ? ref_mem[addr] : '0;
      ed = inj_corrupt ? '0 : rb;
      ee = inj_rerr;
    end
  endtask

  task automatic do_cmd(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    logic [DW-1:0] ed;
    logic ee;
    int n, aw0, w0, b0, ar0, r0, vfy;
    model(we, addr, wd, ed, ee);
`ifdef LSTM_SEQ_READBACK_EN
    vfy = 1;
`else
    vfy = 0;
`endif
    n = 0;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!cmd_ready) begin chk("cmd_ready_timeout", cmd_ready, 1); return; end
    aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_ready_busy", cmd_ready, 0);
    if (we) begin
      chk("awvalid_after_accept", m_awvalid, 1);
      chk("wvalid_after_accept", m_wvalid, 1);
      chk("awaddr", m_awaddr, addr);
      chk("wdata", m_wdata, wd);
      chk("wstrb", m_wstrb, 4'hF);
    end else begin
      chk("arvalid_after_accept", m_arvalid, 1);
      chk("araddr", m_araddr, addr);
    end
    n = 0;
    while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
    chk("rsp_valid_seen", rsp_valid, 1);
    if (!rsp_valid) return;
    chk("rsp_data", rsp_data, ed);
    chk("rsp_err", rsp_err, ee);
    chk("cmd_ready_in_resp", cmd_ready, 0);
    chk("aw_handshakes", n_aw - aw0, we ? 1 : 0);
    chk("w_handshakes", n_w - w0, we ? 1 : 0);
    chk("b_handshakes", n_b - b0, we ? 1 : 0);
    chk("ar_handshakes", n_ar - ar0, we ? vfy : 1);
    chk("r_handshakes", n_r - r0, we ? vfy : 1);
    @(negedge clk);
    chk("rsp_single_pulse", rsp_valid, 0);
    chk("cmd_ready_after_resp", cmd_ready, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_valids"}, {m_awvalid, m_wvalid, m_arvalid, rsp_valid}, 4'b0000);
    chk({tag, "_readies"}, {m_bready, m_rready}, 2'b00);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_addrs"}, {m_awaddr, m_araddr}, 0);
    chk({tag, "_wdata"}, m_wdata, 0);
  endtask

  initial begin : stim
    logic [AW-1:0] a;
    int n;
    rst = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    #2 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    #1 chk("cmd_ready_before_first_edge", cmd_ready, 0);
    @(negedge clk);
    chk("cmd_ready_first_clock", cmd_ready, 1);

    // Basic write then read with an always-ready slave.
    ready_pct = 100;
    do_cmd(1'b1, 32'h10, 32'hDEAD_BEEF);
    do_cmd(1'b0, 32'h10, '0);

    // W channel stalled five cycles after the AW handshake.
    w_delay_mode = 1'b1;
    do_cmd(1'b1, 32'h14, 32'h1234_5678);
    w_delay_mode = 1'b0;

    // SLVERR on a read, then a clean command.
    inj_rerr = 1'b1;
    do_cmd(1'b0, 32'h1FC, '0);
    inj_rerr = 1'b0;
    do_cmd(1'b0, 32'h10, '0);

    // Reset while waiting for the write response.
    b_hold = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h100; cmd_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!m_bready && n < 50) begin @(negedge clk); n++; end
    chk("reached_wr_b", m_bready, 1);
    rst = 1'b1;
    #1 chk_reset_outputs("mid_reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0; b_hold = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_mid_reset", cmd_ready, 1);
    do_cmd(1'b1, 32'h4, 32'h1);
    do_cmd(1'b0, 32'h4, '0);

`ifdef LSTM_SEQ_READBACK_EN
    // Read-back of a write returns a corrupted word.
    inj_corrupt = 1'b1;
    do_cmd(1'b1, 32'h8, 32'h55);
    inj_corrupt = 1'b0;
`endif

    // Randomized traffic with variable slave readiness and injected errors.
    for (int i = 0; i < 40; i++) begin
      ready_pct = $urandom_range(100, 30);
      inj_berr  = ($urandom_range(7) == 0);
      inj_rerr  = ($urandom_range(7) == 0);
      a = AW'($urandom_range(15)) << 2;
      do_cmd(1'($urandom_range(1)), a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lstm_axi_cmd_sequencer.md
# lstm_axi_cmd_sequencer

Single-outstanding AXI4-Lite master that turns a simple valid/ready command port into AXI4-Lite write and read transactions against `axi4_lite_lstm_layers` (weight/bias loads, input writes, result and status reads). It sits between the host-side command source and the LSTM register/memory map and serialises all accesses. It also reports a per-command response word with an error flag.

## Interface
- `AXI_WIDTH`, default 32: data width of `cmd_wdata`, `rsp_data`, `m_wdata` and `m_rdata`; `m_wstrb` width is `AXI_WIDTH/8`.
- `ADDR_WIDTH`, default 32: width of `cmd_addr`, `m_awaddr` and `m_araddr`.
- `clk`  in  1  single clock; every output is registered on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  byte address, passed to AXI unaltered.
- `cmd_wdata`  in  AXI_WIDTH  write data.
- `rsp_valid`  out  1  one-cycle response pulse; there is no backpressure on this port.
- `rsp_data`  out  AXI_WIDTH  read data (read-back data for verified writes, else 0).
- `rsp_err`  out  1  SLVERR/DECERR seen, or read-back mismatch.
- `m_awaddr`  out  ADDR_WIDTH, `m_awvalid`  out  1, `m_awready`  in  1: write address channel.
- `m_wdata`  out  AXI_WIDTH, `m_wstrb`  out  AXI_WIDTH/8 (constant all-ones), `m_wvalid`  out  1, `m_wready`  in  1: write data channel.
- `m_bresp`  in  2, `m_bvalid`  in  1, `m_bready`  out  1: write response channel.
- `m_araddr`  out  ADDR_WIDTH, `m_arvalid`  out  1, `m_arready`  in  1: read address channel.
- `m_rdata`  in  AXI_WIDTH, `m_rresp`  in  2, `m_rvalid`  in  1, `m_rready`  out  1: read data channel.
- The slave's `awprot` and `arprot` are not driven by this block; tie them to 3'b000 at integration.

## Operation
- States: IDLE, WR (AW and W issued together), WR_B, RD_AR, RD_R, VFY_AR, VFY_R (VFY_* exist only with the macro), RESP.
- **IDLE:** `cmd_valid && cmd_ready` latches `cmd_we`, `cmd_addr` and `cmd_wdata`; the next state is WR if `cmd_we` is 1, else RD_AR.
- **WR:**
  - `m_awvalid` and `m_wvalid` rise together.
  - Each valid drops independently on its own handshake; AW and W may complete in either order or in the same cycle.
  - Once both have completed, go to WR_B.
- **WR_B:** `m_bready` is 1. On `m_bvalid`, `err_q <= m_bresp[1]`; go to VFY_AR (macro on) or RESP.
- **RD_AR:** `m_arvalid` is held until `m_arready`, then go to RD_R.
- **RD_R:** `m_rready` is 1. On `m_rvalid`, `data_q <= m_rdata` and `err_q <= m_rresp[1]`; go to RESP.
- **RESP:**
  - `rsp_valid` is 1 for exactly one cycle, carrying `data_q` and `err_q`.
  - Next state is IDLE.
  - `err_q` and `data_q` are cleared on the next command accept.
- Valids are never withdrawn before their handshake. Address and data outputs are stable while the corresponding valid is high.
- Only one command is outstanding at a time; AXI IDs and reordering do not apply.

## Timing
- **Reset values:** all `m_*valid`, `m_bready`, `m_rready`, `rsp_valid`, `rsp_err` and `cmd_ready` are 0; addresses and data are 0.
- `cmd_ready` rises in the first clock after `rst` deasserts.
- Command accepted at edge N → AXI valids high in cycle N+1.
- AXI response accepted at edge K → `rsp_valid` high in cycle K+1 → `cmd_ready` high in cycle K+2.
- With an always-ready slave that responds one cycle after its address handshake, a write or read takes 4 cycles from command accept to `rsp_valid`.
- Back-to-back commands: one command per (latency + 1) cycles at best; `cmd_ready` is 0 in RESP.
- An early `m_bvalid` or `m_rvalid` (before `m_bready`/`m_rready` is driven) is simply held by the slave; the sequencer does not sample it.
- `rst` asserted mid-transaction: the state returns to IDLE and all outputs go to reset values immediately (asynchronous reset). The slave must be reset by the same `rst`.

## Configuration
- **`LSTM_SEQ_READBACK_EN` defined:**
  - After WR_B, the sequencer issues a read to the same address (VFY_AR, then VFY_R).
  - `rsp_data` carries the read-back word.
  - `rsp_err = bresp[1] | rresp[1] | (rdata != wdata)`.
  - Write latency increases by the read latency.
- **Macro undefined:** the VFY states and compare logic are absent; a write's `rsp_data` is 0 and `rsp_err = bresp[1]`.

## Test plan
- After reset, with an always-ready slave: write 0x0000_0010 = 0xDEAD_BEEF → one `m_awvalid`/`m_wvalid` handshake, `m_wstrb` = 4'hF, `rsp_valid` with `rsp_err` = 0, and `rsp_data` = 0 (macro off) or 0xDEAD_BEEF (macro on).
- Read 0x0000_0010 → AR handshake carries address 0x10, `rsp_data` = 0xDEAD_BEEF, `rsp_err` = 0; a single `rsp_valid` pulse.
- Slave holds `m_wready` low for 5 cycles after `m_awready` → `m_wvalid` stays high with stable data, `m_awvalid` drops after its handshake, and exactly one B is accepted.
- Slave returns `m_rresp` = 2'b10 on a read of 0x1FC → `rsp_err` = 1; the next command's `rsp_err` is 0.
- Assert `rst` while in WR_B → outputs return to reset values in the same cycle; after release, a new write of 0x4 = 0x1 completes normally.
- Macro on, slave corrupts read-back of 0x8 (returns 0x0 after a write of 0x55) → `rsp_err` = 1 and `rsp_data` = 0x0.
